bus_ctrl: RTL and testbench

Bus controller on the responder side of the CPU's bus request interface (`cpu_bc_*` in, `bc_cpu_*` out). It decodes every CPU load/store into a single-port synchronous data RAM or a small MMIO register bank (GPIO, cycle counter, error status). It inserts RAM wait states and returns one completion pulse per request. It sits beside the CPU inside the core top level.

---
 rtl/bus_pkg.sv | 30 +++
 rtl/mmio_regs.sv | 65 ++++++
 rtl/bus_ctrl.sv | 150 +++++++++++++++
 tb/tb_bus_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus controller: MMIO address map, FSM states
// and the value returned for a read that decodes to nothing.
package bus_pkg;

    localparam logic [31:0] GPIO_ADDR    = 32'hFFFF_0000;
    localparam logic [31:0] COUNTER_ADDR = 32'hFFFF_0004;
    localparam logic [31:0] ERRSTAT_ADDR = 32'hFFFF_0008;

    localparam logic [31:0] BAD_READ_VAL = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        WAIT,
        RESP
    } bus_state_e;

    // Register select inside the MMIO bank, taken from address bits [3:2]
    typedef enum logic [1:0] {
        REG_GPIO    = 2'd0,
        REG_COUNTER = 2'd1,
        REG_ERRSTAT = 2'd2,
        REG_NONE    = 2'd3
    } mmio_reg_e;

    function automatic logic is_mmio_addr(input logic [31:0] addr);
        return (addr == GPIO_ADDR) || (addr == COUNTER_ADDR) || (addr == ERRSTAT_ADDR);
    endfunction

endpackage

// File: rtl/mmio_regs.sv
// MMIO register bank: GPIO output, free-running cycle counter and sticky
// bus-error flag, with a single write port and a combinational read mux.
module mmio_regs
    import bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_i,
    input  mmio_reg_e   sel_i,
    input  logic [31:0] wdata_i,
    input  logic        set_err_i,
    output logic [31:0] rdata_o,
    output logic [31:0] gpio_o,
    output logic        err_o
);

    logic [31:0] gpio_q, gpio_d;
    logic [31:0] counter_q, counter_d;
    logic        err_q, err_d;

    // Next-state for the bank; a counter write overrides the increment
    always_comb begin
        gpio_d    = gpio_q;
        counter_d = counter_q + 32'd1;
        err_d     = err_q;
        if (set_err_i) begin
            err_d = 1'b1;
        end
        if (wr_en_i) begin
            case (sel_i)
                REG_GPIO:    gpio_d    = wdata_i;
                REG_COUNTER: counter_d = wdata_i;
                REG_ERRSTAT: err_d     = 1'b0;
                default:     ;
            endcase
        end
    end

    // Register update with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_q    <= '0;
            counter_q <= '0;
            err_q     <= 1'b0;
        end else begin
            gpio_q    <= gpio_d;
            counter_q <= counter_d;
            err_q     <= err_d;
        end
    end

    // Read mux reflecting current register contents
    always_comb begin
        case (sel_i)
            REG_GPIO:    rdata_o = gpio_q;
            REG_COUNTER: rdata_o = counter_q;
            REG_ERRSTAT: rdata_o = {31'b0, err_q};
            default:     rdata_o = BAD_READ_VAL;
        endcase
    end

    assign gpio_o = gpio_q;
    assign err_o  = err_q;

endmodule

// File: rtl/bus_ctrl.sv
// Bus controller: captures one CPU request at a time, decodes it to the
// data RAM or the MMIO bank, sequences RAM read latency and returns a
// single-cycle completion pulse with the read data.
module bus_ctrl
    import bus_pkg::*;
#(
    parameter int RAM_AW   = 10,
    parameter int RAM_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_bc_req,
    input  logic              cpu_bc_rw,
    input  logic [31:0]       cpu_bc_addr,
    input  logic [31:0]       cpu_bc_data,
    output logic [31:0]       bc_cpu_data,
    output logic              bc_cpu_ready,
    output logic              bc_ram_en,
    output logic              bc_ram_we,
    output logic [RAM_AW-1:0] bc_ram_addr,
    output logic [31:0]       bc_ram_wdata,
    input  logic [31:0]       ram_bc_rdata,
    output logic [31:0]       bc_gpio_out,
    output logic              bc_err
);

    bus_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  wait_q, wait_d;

    logic        hit_ram;
    logic        hit_mmio;
    mmio_reg_e   mmio_sel;
    logic [31:0] mmio_rdata;
    logic        mmio_we;
    logic        set_err;
    logic        ram_en;
    logic        ram_we;

    // Address decode of the captured request; misaligned never hits anything
    always_comb begin
        hit_ram  = (addr_q[1:0] == 2'b00) && (addr_q[31:RAM_AW+2] == '0);
        hit_mmio = is_mmio_addr(addr_q);
        mmio_sel = hit_mmio ? mmio_reg_e'(addr_q[3:2]) : REG_NONE;
    end

    // FSM next-state, capture and strobe generation
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        wait_d  = wait_q;
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        mmio_we = 1'b0;
        set_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_bc_req) begin
                    addr_d  = cpu_bc_addr;
                    wdata_d = cpu_bc_data;
                    rw_d    = cpu_bc_rw;
                    state_d = ACC;
                end
            end
            ACC: begin
                rdata_d = '0;
                state_d = RESP;
                if (hit_ram) begin
                    ram_en = 1'b1;
                    ram_we = rw_q;
                    if (!rw_q) begin
                        wait_d  = 2'(RAM_WAIT);
                        state_d = WAIT;
                    end
                end else if (hit_mmio) begin
                    mmio_we = rw_q;
                    if (!rw_q) begin
                        rdata_d = mmio_rdata;
                    end
                end else begin
                    set_err = 1'b1;
                    if (!rw_q) begin
                        rdata_d = BAD_READ_VAL;
                    end
                end
            end
            WAIT: begin
                if (wait_q == 2'd1) begin
                    rdata_d = ram_bc_rdata;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and capture registers; reset abandons any in-flight request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            rdata_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
        end
    end

    mmio_regs u_mmio_regs (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (mmio_we),
        .sel_i     (mmio_sel),
        .wdata_i   (wdata_q),
        .set_err_i (set_err),
        .rdata_o   (mmio_rdata),
        .gpio_o    (bc_gpio_out),
        .err_o     (bc_err)
    );

    // RAM strobes are decoded from the state so reset drops them at once
    assign bc_ram_en    = ram_en;
    assign bc_ram_we    = ram_we;
    assign bc_ram_addr  = addr_q[RAM_AW+1:2];
    assign bc_ram_wdata = wdata_q;

    assign bc_cpu_ready = (state_q == RESP);
    assign bc_cpu_data  = (state_q == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_bus_ctrl.sv
// Testbench for bus_ctrl: two instances (RAM_WAIT 1 and 3) each with a
// behavioural RAM, a directed driver pushing expected responses into a
// queue, and a monitor that pops and compares on every ready pulse.
module tb_bus_ctrl;

    localparam int AW = 10;

    typedef struct {
        logic [31:0] data;
        int          readyCycle;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req      [2];
    logic        rw       [2];
    logic [31:0] addr     [2];
    logic [31:0] wdata    [2];
    logic [31:0] rdata    [2];
    logic        rdy      [2];
    logic        ramEn    [2];
    logic        ramWe    [2];
    logic [AW-1:0] ramAddr [2];
    logic [31:0] ramWdata [2];
    logic [31:0] ramRdata [2];
    logic [31:0] gpio     [2];
    logic        err      [2];

    logic [31:0] mem  [2][1024];
    logic [31:0] pipe [2][3];

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    int enCount [2] = '{0, 0};
    int lastEnCycle [2];
    logic [AW-1:0] lastEnAddr [2];
    logic lastEnWe [2];
    bit inReady [2] = '{0, 0};
    exp_t sb0 [$];
    exp_t sb1 [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bus_ctrl #(.RAM_AW(AW), .RAM_WAIT(1)) dut (
        .clk(clk), .rst(rst),
        .cpu_bc_req(req[0]), .cpu_bc_rw(rw[0]), .cpu_bc_addr(addr[0]), .cpu_bc_data(wdata[0]),
        .bc_cpu_data(rdata[0]), .bc_cpu_ready(rdy[0]),
        .bc_ram_en(ramEn[0]), .bc_ram_we(ramWe[0]), .bc_ram_addr(ramAddr[0]),
        .bc_ram_wdata(ramWdata[0]), .ram_bc_rdata(ramRdata[0]),
        .bc_gpio_out(gpio[0]), .bc_err(err[0])
    );

    bus_ctrl #(.RAM_AW(AW), .RAM_WAIT(3)) dut3 (
        .clk(clk), .rst(rst),
        .cpu_bc_req(req[1]), .cpu_bc_rw(rw[1]), .cpu_bc_addr(addr[1]), .cpu_bc_data(wdata[1]),
        .bc_cpu_data(rdata[1]), .bc_cpu_ready(rdy[1]),
        .bc_ram_en(ramEn[1]), .bc_ram_we(ramWe[1]), .bc_ram_addr(ramAddr[1]),
        .bc_ram_wdata(ramWdata[1]), .ram_bc_rdata(ramRdata[1]),
        .bc_gpio_out(gpio[1]), .bc_err(err[1])
    );

    // Synchronous RAM with 1-cycle core latency plus extra output stages
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ramEn[k] && ramWe[k]) mem[k][ramAddr[k]] <= ramWdata[k];
            if (ramEn[k] && !ramWe[k]) pipe[k][0] <= mem[k][ramAddr[k]];
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end
    assign ramRdata[0] = pipe[0][0];
    assign ramRdata[1] = pipe[1][2];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic pushExp(input int k, input exp_t e);
        if (k == 0) sb0.push_back(e); else sb1.push_back(e);
    endtask

    task automatic popExp(input int k, output exp_t e, output bit ok);
        ok = 1'b0;
        if (k == 0 && sb0.size() > 0) begin e = sb0.pop_front(); ok = 1'b1; end
        if (k == 1 && sb1.size() > 0) begin e = sb1.pop_front(); ok = 1'b1; end
    endtask

    // RAM enable activity, sampled mid-cycle
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ramEn[k]) begin
                enCount[k]     <= enCount[k] + 1;
                lastEnCycle[k] <= cyc;
                lastEnAddr[k]  <= ramAddr[k];
                lastEnWe[k]    <= ramWe[k];
            end
        end
    end

    // Monitor: every ready pulse must match the oldest expected response
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            bit ok;
            if (rdy[k]) begin
                popExp(k, e, ok);
                if (!ok) begin
                    checkOutput($sformatf("dut%0d unexpected ready", k), 32'd1, 32'd0);
                end else begin
                    checkOutput({e.name, " data"}, rdata[k], e.data);
                    checkOutput({e.name, " ready cycle"}, 32'(cyc), 32'(e.readyCycle));
                end
            end else if (rdata[k] !== 32'd0) begin
                checkOutput($sformatf("dut%0d data while idle", k), rdata[k], 32'd0);
            end
        end
    end

    // Issue one request (called at a negedge) and wait for its ready pulse;
    // req stays high afterwards so a following call is a back-to-back request
    task automatic applyStimulus(input int k, input bit w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [31:0] expData,
                                 input int lat, input int expEn, input string name);
        int issue;
        int enBefore;
        int t;
        exp_t e;
        issue    = inReady[k] ? cyc + 1 : cyc;
        enBefore = enCount[k];
        rw[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        req[k]   = 1'b1;
        e.data       = expData;
        e.readyCycle = issue + lat;
        e.name       = name;
        pushExp(k, e);
        inReady[k] = 1'b0;
        @(negedge clk);
        t = 1;
        while (!rdy[k] && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!rdy[k]) checkOutput({name, " ready timeout"}, 32'd0, 32'd1);
        inReady[k] = 1'b1;
        checkOutput({name, " ram enable cycles"}, 32'(enCount[k] - enBefore), 32'(expEn));
        if (expEn != 0) begin
            checkOutput({name, " ram addr"}, 32'(lastEnAddr[k]), 32'(a[AW+1:2]));
            checkOutput({name, " ram we"}, 32'(lastEnWe[k]), 32'(w));
            checkOutput({name, " ram en cycle"}, 32'(lastEnCycle[k]), 32'(issue + 1));
        end
    endtask

    task automatic idle(input int k, input int n);
        req[k] = 1'b0;
        repeat (n) @(negedge clk);
        inReady[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; rw[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
        end
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst ready", 32'(rdy[0]), 32'd0);
        checkOutput("rst data", rdata[0], 32'd0);
        checkOutput("rst ram en", 32'(ramEn[0]), 32'd0);
        checkOutput("rst ram we", 32'(ramWe[0]), 32'd0);
        checkOutput("rst ram addr", 32'(ramAddr[0]), 32'd0);
        checkOutput("rst ram wdata", ramWdata[0], 32'd0);
        checkOutput("rst gpio", gpio[0], 32'd0);
        checkOutput("rst err", 32'(err[0]), 32'd0);
        checkOutput("rst dut3 ready", 32'(rdy[1]), 32'd0);

        // Counter is 0 in the release cycle, so the ACC-cycle value is 1
        rst = 1'b0;
        applyStimulus(0, 1'b0, 32'hFFFF_0004, 32'h0, 32'h1, 2, 0, "counter after reset");
        idle(0, 2);

        // RAM write then read back, plus top word of the RAM
        applyStimulus(0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 2, 1, "ram write 0x10");
        applyStimulus(0, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 3, 1, "ram read 0x10");
        idle(0, 2);
        applyStimulus(0, 1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF, 32'h0, 2, 1, "ram write top");
        applyStimulus(0, 1'b0, 32'h0000_0FFC, 32'h0, 32'hDEAD_BEEF, 3, 1, "ram read top");
        idle(0, 1);

        // GPIO write visible in the ready cycle, then read back
        applyStimulus(0, 1'b1, 32'hFFFF_0000, 32'h0000_00A5, 32'h0, 2, 0, "gpio write");
        checkOutput("gpio out", gpio[0], 32'h0000_00A5);
        applyStimulus(0, 1'b0, 32'hFFFF_0000, 32'h0, 32'h0000_00A5, 2, 0, "gpio read");
        idle(0, 2);

        // Counter load and wrap: ACC of first read is 2 cycles after load
        applyStimulus(0, 1'b1, 32'hFFFF_0004, 32'hFFFF_FFFE, 32'h0, 2, 0, "counter write");
        applyStimulus(0, 1'b0, 32'hFFFF_0004, 32'h0, 32'h0000_0000, 2, 0, "counter read 1");
        applyStimulus(0, 1'b0, 32'hFFFF_0004, 32'h0, 32'h0000_0003, 2, 0, "counter read 2");
        idle(0, 2);

        // Bad accesses set err, never touch RAM, and complete normally
        checkOutput("err before bad", 32'(err[0]), 32'd0);
        applyStimulus(0, 1'b0, 32'h0000_0003, 32'h0, 32'h0, 2, 0, "bad read misaligned");
        applyStimulus(0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 2, 0, "bad read unmapped");
        checkOutput("err after bad", 32'(err[0]), 32'd1);
        applyStimulus(0, 1'b1, 32'h0000_1000, 32'h5555_5555, 32'h0, 2, 0, "bad write past ram");
        applyStimulus(0, 1'b1, 32'hFFFF_0002, 32'h0000_00FF, 32'h0, 2, 0, "bad write gpio misaligned");
        checkOutput("gpio after bad write", gpio[0], 32'h0000_00A5);
        applyStimulus(0, 1'b0, 32'hFFFF_0008, 32'h0, 32'h1, 2, 0, "errstat read set");
        applyStimulus(0, 1'b1, 32'hFFFF_0008, 32'h55, 32'h0, 2, 0, "errstat clear");
        checkOutput("err after clear", 32'(err[0]), 32'd0);
        applyStimulus(0, 1'b0, 32'hFFFF_0008, 32'h0, 32'h0, 2, 0, "errstat read clear");
        idle(0, 2);

        // Reset during the WAIT state of a RAM read drops the request
        rw[0] = 1'b0; addr[0] = 32'h0000_0010; req[0] = 1'b1;
        @(negedge clk);
        checkOutput("abort acc ram en", 32'(ramEn[0]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        req[0] = 1'b0;
        #1;
        checkOutput("abort ready", 32'(rdy[0]), 32'd0);
        checkOutput("abort data", rdata[0], 32'd0);
        checkOutput("abort ram en", 32'(ramEn[0]), 32'd0);
        checkOutput("abort gpio", gpio[0], 32'd0);
        checkOutput("abort err", 32'(err[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        inReady[0] = 1'b0;
        @(negedge clk);
        applyStimulus(0, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 3, 1, "ram read after reset");
        idle(0, 3);

        // RAM_WAIT=3 instance with req held high across a stream
        applyStimulus(1, 1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0, 2, 1, "w3 write 0x20");
        applyStimulus(1, 1'b1, 32'h0000_0024, 32'h2222_2222, 32'h0, 2, 1, "w3 write 0x24");
        applyStimulus(1, 1'b0, 32'h0000_0020, 32'h0, 32'h1111_1111, 5, 1, "w3 read 0x20");
        applyStimulus(1, 1'b0, 32'h0000_0024, 32'h0, 32'h2222_2222, 5, 1, "w3 read 0x24");
        applyStimulus(1, 1'b1, 32'hFFFF_0000, 32'h0000_0007, 32'h0, 2, 0, "w3 gpio write");
        applyStimulus(1, 1'b0, 32'hFFFF_0000, 32'h0, 32'h0000_0007, 2, 0, "w3 gpio read");
        applyStimulus(1, 1'b0, 32'h0000_0020, 32'h0, 32'h1111_1111, 5, 1, "w3 read 0x20 again");
        idle(1, 4);

        checkOutput("dut0 outstanding", 32'(sb0.size()), 32'd0);
        checkOutput("dut3 outstanding", 32'(sb1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
